// File: rtl/pwm_comp_multi.sv
// Multi-channel complementary PWM with shared period counter, programmable dead
// time, shadow-registered duty updates and a latched brake.
module pwm_comp_lane #(
  parameter int WIDTH = 12,
  parameter int DEAD  = 44
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stay_run,
  input  logic             in_run,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_vld,
  output logic             pwm_hi,
  output logic             pwm_lo
);
  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [WIDTH-1:0] DW   = WIDTH'(DEAD);
  localparam logic [WIDTH-1:0] DMAX = CMAX - DW;

  logic [WIDTH-1:0] pending, active, deff;
  logic [WIDTH:0]   lo_on;
  logic             ld_act;

  // active only moves at a period boundary while running, so no runt pulses
  assign ld_act = !in_run || (cnt == CMAX);
  assign deff   = (active > DMAX) ? DMAX : active;
  assign lo_on  = {1'b0, deff} + {1'b0, DW};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      active  <= '0;
      pwm_hi  <= 1'b0;
      pwm_lo  <= 1'b0;
    end else begin
      if (duty_vld) pending <= duty;
      if (ld_act)   active  <= duty_vld ? duty : pending;
      if (!stay_run) begin
        pwm_hi <= 1'b0;
        pwm_lo <= 1'b0;
      end else begin
        if (cnt >= deff)               pwm_hi <= 1'b0;
        else if (cnt >= DW)            pwm_hi <= 1'b1;
        if (cnt == CMAX)               pwm_lo <= 1'b0;
        else if ({1'b0, cnt} >= lo_on) pwm_lo <= 1'b1;
      end
    end
  end
endmodule

module pwm_comp_multi #(
  parameter int WIDTH = 12,
  parameter int NCH   = 2,
  parameter int DEAD  = 44
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 brake,
  input  logic [NCH*WIDTH-1:0] duty,
  input  logic [NCH-1:0]       duty_vld,
  output logic [NCH-1:0]       pwm_hi,
  output logic [NCH-1:0]       pwm_lo,
  output logic                 period_end,
  output logic                 braked
);
  typedef enum logic [1:0] {IDLE, RUN, BRAKE} state_t;

  localparam logic [WIDTH-1:0] CLAST = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t                       state, nxt;
  logic [WIDTH-1:0]             cnt;
  logic                         stay_run, in_run;
  logic [NCH-1:0][WIDTH-1:0]    duty_a;

  assign duty_a = duty;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (en)  nxt = RUN;
      RUN:     if (!en) nxt = IDLE;
      BRAKE:   if (!en) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (brake) nxt = BRAKE;
  end

  // outputs drop on any edge that leaves RUN, including the brake edge
  assign in_run   = (state == RUN);
  assign stay_run = in_run && (nxt == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      period_end <= 1'b0;
      braked     <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= stay_run ? cnt + 1'b1 : '0;
      period_end <= stay_run && (cnt == CLAST);
      braked     <= (nxt == BRAKE);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    pwm_comp_lane #(.WIDTH(WIDTH), .DEAD(DEAD)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .stay_run (stay_run),
      .in_run   (in_run),
      .cnt      (cnt),
      .duty     (duty_a[k]),
      .duty_vld (duty_vld[k]),
      .pwm_hi   (pwm_hi[k]),
      .pwm_lo   (pwm_lo[k])
    );
  end
endmodule

// File: tb/tb_pwm_comp_multi.sv
// Bench for pwm_comp_multi: positional waveform reference plus per-period
// pulse-width, dead-gap, brake and reset scenarios.
module tb_pwm_comp_multi;
  localparam int W = 12, NCH = 2, DEAD = 44;
  localparam int PER = 1 << W, MAXC = PER - 1, DMAX = MAXC - DEAD;
  localparam int M_IDLE = 0, M_RUN = 1, M_BRAKE = 2;

  logic             clk = 1'b0, rst_n = 1'b0, en = 1'b0, brake = 1'b0;
  logic [NCH*W-1:0] duty = '0;
  logic [NCH-1:0]   duty_vld = '0;
  logic [NCH-1:0]   pwm_hi, pwm_lo;
  logic             period_end, braked;

  int n_chk = 0, n_fail = 0;
  int ms = M_IDLE, mc = 0;
  int m_pend[NCH], m_act[NCH];
  logic [NCH-1:0] e_hi, e_lo;
  logic           e_pe, e_brk;
  int wave_bad, overlap, pe_cnt, cyc;
  int hi_cnt[NCH], lo_cnt[NCH];
  int first_hi, last_hi, first_lo, last_lo;
  string bad_msg;

  pwm_comp_multi #(.WIDTH(W), .NCH(NCH), .DEAD(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .brake(brake), .duty(duty),
    .duty_vld(duty_vld), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo),
    .period_end(period_end), .braked(braked));

  always #5 clk = ~clk;

  function automatic int deff(input int a);
    return (a > DMAX) ? DMAX : a;
  endfunction

  function automatic int hi_w(input int d);
    return (deff(d) > DEAD) ? deff(d) - DEAD : 0;
  endfunction

  // One clock: model expectations come from the position inside the period.
  task automatic step();
    int ns, nc;
    bit cont;
    ns = ms;
    if (brake)                    ns = M_BRAKE;
    else if (ms == M_IDLE && en)  ns = M_RUN;
    else if (ms == M_RUN && !en)  ns = M_IDLE;
    else if (ms == M_BRAKE && !en) ns = M_IDLE;
    cont = (ms == M_RUN) && (ns == M_RUN);
    nc = cont ? (mc + 1) % PER : 0;
    for (int k = 0; k < NCH; k++) begin
      if (ms != M_RUN || mc == MAXC)
        m_act[k] = duty_vld[k] ? int'(duty[k*W +: W]) : m_pend[k];
      if (duty_vld[k]) m_pend[k] = int'(duty[k*W +: W]);
      e_hi[k] = cont && (nc > DEAD) && (nc <= deff(m_act[k]));
      e_lo[k] = cont && (nc > deff(m_act[k]) + DEAD);
    end
    e_pe  = cont && (nc == MAXC);
    e_brk = (ns == M_BRAKE);
    ms = ns;
    mc = nc;
    @(posedge clk);
    #1;
    cyc++;
    if ({pwm_hi, pwm_lo, period_end, braked} !== {e_hi, e_lo, e_pe, e_brk}) begin
      if (wave_bad == 0)
        bad_msg = $sformatf("cyc %0d got hi=%b lo=%b pe=%b brk=%b, want hi=%b lo=%b pe=%b brk=%b",
                            cyc, pwm_hi, pwm_lo, period_end, braked, e_hi, e_lo, e_pe, e_brk);
      wave_bad++;
    end
    if (|(pwm_hi & pwm_lo)) overlap++;
    if (period_end === 1'b1) pe_cnt++;
    for (int k = 0; k < NCH; k++) begin
      if (pwm_hi[k] === 1'b1) hi_cnt[k]++;
      if (pwm_lo[k] === 1'b1) lo_cnt[k]++;
    end
  endtask

  task automatic sync(output bit ok);
    for (int i = 0; i < PER + 8 && period_end !== 1'b1; i++) step();
    ok = (period_end === 1'b1);
  endtask

  // Runs one full period from a boundary; boundary writes are set by the caller,
  // wr_at is the cnt value of the cycle carrying a mid-period write (-1: none).
  task automatic measure_period(input int wr_at, input int wr_ch, input int wr_val);
    pe_cnt = 0; first_hi = -1; last_hi = -1; first_lo = -1; last_lo = -1;
    for (int k = 0; k < NCH; k++) begin hi_cnt[k] = 0; lo_cnt[k] = 0; end
    for (int i = 0; i < PER; i++) begin
      if (wr_at >= 0 && i == wr_at + 1) begin
        duty[wr_ch*W +: W] = W'(wr_val);
        duty_vld[wr_ch] = 1'b1;
      end
      step();
      duty_vld = '0;
      if (pwm_hi[0] === 1'b1) begin if (first_hi < 0) first_hi = i; last_hi = i; end
      if (pwm_lo[0] === 1'b1) begin if (first_lo < 0) first_lo = i; last_lo = i; end
    end
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({pwm_hi, pwm_lo, period_end, braked} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0", {pwm_hi, pwm_lo, period_end, braked});
    end
    rst_n = 1'b1;
    wave_bad = 0;
    repeat (3) step();
    n_chk++;
    if (wave_bad !== 0) begin n_fail++; $display("FAIL reset_idle_wave: %0d bad, %s", wave_bad, bad_msg); end
  endtask

  task automatic test_basic();
    bit ok;
    wave_bad = 0; overlap = 0;
    duty = {W'('h800), W'('h800)}; duty_vld = '1; en = 1'b1;
    step();
    duty_vld = '0;
    sync(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL basic_sync: got no period_end want one within %0d", PER); end
    measure_period(-1, 0, 0);
    n_chk++;
    if (hi_cnt[0] !== 2004) begin n_fail++; $display("FAIL basic_hi0: got %0d want 2004", hi_cnt[0]); end
    n_chk++;
    if (lo_cnt[0] !== 2003) begin n_fail++; $display("FAIL basic_lo0: got %0d want 2003", lo_cnt[0]); end
    n_chk++;
    if (hi_cnt[1] !== 2004 || lo_cnt[1] !== 2003) begin
      n_fail++; $display("FAIL basic_ch1: got hi %0d lo %0d want 2004 2003", hi_cnt[1], lo_cnt[1]);
    end
    n_chk++;
    if (first_lo - last_hi - 1 !== DEAD) begin
      n_fail++; $display("FAIL basic_gap_hi_lo: got %0d want %0d", first_lo - last_hi - 1, DEAD);
    end
    n_chk++;
    if (first_hi + PER - last_lo - 1 !== DEAD + 1) begin
      n_fail++; $display("FAIL basic_gap_lo_hi: got %0d want %0d", first_hi + PER - last_lo - 1, DEAD + 1);
    end
    n_chk++;
    if (pe_cnt !== 1 || period_end !== 1'b1) begin
      n_fail++; $display("FAIL basic_period_end: got %0d pulses, last=%b want 1, 1", pe_cnt, period_end);
    end
    n_chk++;
    if (overlap !== 0 || wave_bad !== 0) begin
      n_fail++; $display("FAIL basic_wave: overlap %0d bad %0d want 0 0, %s", overlap, wave_bad, bad_msg);
    end
  endtask

  task automatic test_clamp();
    wave_bad = 0; overlap = 0;
    duty[0 +: W] = W'('h010); duty_vld[0] = 1'b1;
    measure_period(-1, 0, 0);
    n_chk++;
    if (hi_cnt[0] !== 0 || lo_cnt[0] !== 4035) begin
      n_fail++; $display("FAIL low_duty_ch0: got hi %0d lo %0d want 0 4035", hi_cnt[0], lo_cnt[0]);
    end
    n_chk++;
    if (hi_cnt[1] !== 2004 || lo_cnt[1] !== 2003) begin
      n_fail++; $display("FAIL low_duty_ch1: got hi %0d lo %0d want 2004 2003", hi_cnt[1], lo_cnt[1]);
    end
    duty[0 +: W] = W'('hFFF); duty_vld[0] = 1'b1;
    measure_period(-1, 0, 0);
    n_chk++;
    if (hi_cnt[0] !== 4007 || lo_cnt[0] !== 0) begin
      n_fail++; $display("FAIL clamp_ch0: got hi %0d lo %0d want 4007 0", hi_cnt[0], lo_cnt[0]);
    end
    n_chk++;
    if (overlap !== 0 || wave_bad !== 0) begin
      n_fail++; $display("FAIL clamp_wave: overlap %0d bad %0d want 0 0, %s", overlap, wave_bad, bad_msg);
    end
  endtask

  task automatic test_update();
    wave_bad = 0;
    duty[0 +: W] = W'('h400); duty_vld[0] = 1'b1;
    measure_period('h100, 0, 'hC00);
    n_chk++;
    if (hi_cnt[0] !== 'h400 - DEAD) begin
      n_fail++; $display("FAIL update_cur: got %0d want %0d", hi_cnt[0], 'h400 - DEAD);
    end
    measure_period(-1, 0, 0);
    n_chk++;
    if (hi_cnt[0] !== 3028) begin n_fail++; $display("FAIL update_next: got %0d want 3028", hi_cnt[0]); end
    n_chk++;
    if (hi_cnt[1] !== 2004 || wave_bad !== 0) begin
      n_fail++; $display("FAIL update_ch1_wave: got hi1 %0d bad %0d want 2004 0, %s", hi_cnt[1], wave_bad, bad_msg);
    end
  endtask

  task automatic test_random();
    int d0, d1_next, d1_cur;
    d1_cur = 'h800;
    wave_bad = 0; overlap = 0;
    for (int p = 0; p < 4; p++) begin
      d0 = (p == 0) ? DEAD : (p == 1) ? DEAD + 1 : int'($urandom_range(MAXC, 0));
      d1_next = int'($urandom_range(MAXC, 0));
      duty[0 +: W] = W'(d0); duty_vld[0] = 1'b1;
      measure_period(int'($urandom_range(4000, 20)), 1, d1_next);
      n_chk++;
      if (hi_cnt[0] !== hi_w(d0) || lo_cnt[0] !== MAXC - deff(d0) - DEAD) begin
        n_fail++; $display("FAIL rand_ch0 p%0d duty %0d: got hi %0d lo %0d want %0d %0d",
                           p, d0, hi_cnt[0], lo_cnt[0], hi_w(d0), MAXC - deff(d0) - DEAD);
      end
      n_chk++;
      if (hi_cnt[1] !== hi_w(d1_cur) || lo_cnt[1] !== MAXC - deff(d1_cur) - DEAD) begin
        n_fail++; $display("FAIL rand_ch1 p%0d duty %0d: got hi %0d lo %0d want %0d %0d",
                           p, d1_cur, hi_cnt[1], lo_cnt[1], hi_w(d1_cur), MAXC - deff(d1_cur) - DEAD);
      end
      d1_cur = d1_next;
    end
    n_chk++;
    if (overlap !== 0 || wave_bad !== 0) begin
      n_fail++; $display("FAIL rand_wave: overlap %0d bad %0d want 0 0, %s", overlap, wave_bad, bad_msg);
    end
  endtask

  task automatic test_brake();
    int n;
    wave_bad = 0;
    duty[0 +: W] = W'('h800); duty_vld[0] = 1'b1;
    step();
    duty_vld = '0;
    repeat (100) step();
    n_chk++;
    if (pwm_hi[0] !== 1'b1) begin n_fail++; $display("FAIL brake_pre_hi: got %b want 1", pwm_hi[0]); end
    brake = 1'b1;
    step();
    brake = 1'b0;
    n_chk++;
    if ({pwm_hi, pwm_lo} !== '0 || braked !== 1'b1) begin
      n_fail++; $display("FAIL brake_hit: got hi %b lo %b braked %b want 0 0 1", pwm_hi, pwm_lo, braked);
    end
    repeat (20) step();
    n_chk++;
    if ({pwm_hi, pwm_lo, period_end} !== '0 || braked !== 1'b1) begin
      n_fail++; $display("FAIL brake_hold: got hi %b lo %b braked %b want 0 0 1", pwm_hi, pwm_lo, braked);
    end
    en = 1'b0;
    step();
    en = 1'b1;
    n_chk++;
    if (braked !== 1'b0) begin n_fail++; $display("FAIL brake_release: got %b want 0", braked); end
    step();
    n = 0;
    while (pwm_hi[0] !== 1'b1 && n < 200) begin step(); n++; end
    n_chk++;
    if (n !== DEAD + 1) begin n_fail++; $display("FAIL brake_restart: hi rose after %0d want %0d", n, DEAD + 1); end
    n_chk++;
    if (wave_bad !== 0) begin n_fail++; $display("FAIL brake_wave: %0d bad, %s", wave_bad, bad_msg); end
  endtask

  task automatic test_async_reset();
    int n;
    wave_bad = 0;
    repeat (500) step();
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({pwm_hi, pwm_lo, period_end, braked} !== '0) begin
      n_fail++; $display("FAIL async_reset: got %b want 0", {pwm_hi, pwm_lo, period_end, braked});
    end
    ms = M_IDLE; mc = 0;
    for (int k = 0; k < NCH; k++) begin m_pend[k] = 0; m_act[k] = 0; end
    #20 rst_n = 1'b1;
    duty = {W'('h800), W'('h800)}; duty_vld = '1; en = 1'b1;
    step();
    duty_vld = '0;
    n = 0;
    while (pwm_hi[0] !== 1'b1 && n < 200) begin step(); n++; end
    n_chk++;
    if (n !== DEAD + 1) begin n_fail++; $display("FAIL reset_restart: hi rose after %0d want %0d", n, DEAD + 1); end
    n_chk++;
    if (wave_bad !== 0) begin n_fail++; $display("FAIL reset_wave: %0d bad, %s", wave_bad, bad_msg); end
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) begin m_pend[k] = 0; m_act[k] = 0; end
    cyc = 0; wave_bad = 0; overlap = 0; pe_cnt = 0;
    test_reset();
    test_basic();
    test_clamp();
    test_update();
    test_random();
    test_brake();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
